// File: rtl/mem_ctrl.sv
// mem_ctrl: shares one byte-wide RAM/IO port between the instruction cache
// (4-byte fetches) and the load/store buffer (1/2/4-byte loads and stores).
// Each access is split into byte beats. Read data is assembled little-endian.
// The two requesters are arbitrated round-robin.
// Ports:
//   clk, rst (sync, active-high), rdy (global enable), clr (flush icache fetch)
//   ic_req/ic_addr -> ic_done/ic_data        : icache word fetch
//   ls_req/ls_we/ls_size/ls_addr/ls_wdata
//     -> ls_done/ls_rdata                    : load/store buffer access
//   mem_din/mem_dout/mem_a/mem_wr            : byte RAM/IO port
//   io_buffer_full                           : IO sink back-pressure for writes
module mem_ctrl #(
  parameter logic [31:0] IO_BASE = 32'h0003_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        clr,
  input  logic        ic_req,
  input  logic [31:0] ic_addr,
  output logic        ic_done,
  output logic [31:0] ic_data,
  input  logic        ls_req,
  input  logic        ls_we,
  input  logic [1:0]  ls_size,
  input  logic [31:0] ls_addr,
  input  logic [31:0] ls_wdata,
  output logic        ls_done,
  output logic [31:0] ls_rdata,
  input  logic [7:0]  mem_din,
  output logic [7:0]  mem_dout,
  output logic [31:0] mem_a,
  output logic        mem_wr,
  input  logic        io_buffer_full
);

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned BW = 8;
  localparam int unsigned CW = 3;

  typedef enum logic [1:0] {S_IDLE, S_READ, S_WRITE} state_e;

  state_e         state_q, state_d;
  logic           owner_ls_q, owner_ls_d;
  logic           last_ls_q, last_ls_d;
  logic [AW-1:0]  addr_q, addr_d;
  logic [DW-1:0]  wdata_q, wdata_d;
  logic [CW-1:0]  nbeat_q, nbeat_d;
  logic [CW-1:0]  iss_q, iss_d;
  logic [CW-1:0]  rcv_q, rcv_d;
  logic [DW-1:0]  rdata_q, rdata_d;
  logic           ic_done_q, ic_done_d;
  logic [DW-1:0]  ic_data_q, ic_data_d;
  logic           ls_done_q, ls_done_d;
  logic [DW-1:0]  ls_rdata_q, ls_rdata_d;

  logic           ic_elig;
  logic           ls_elig;
  logic           outstanding;
  logic           io_stall;
  logic [CW-1:0]  ls_nbeat;
  logic [4:0]     rd_lane;
  logic [4:0]     wr_lane;

  assign ic_done  = ic_done_q;
  assign ic_data  = ic_data_q;
  assign ls_done  = ls_done_q;
  assign ls_rdata = ls_rdata_q;

  // A requester whose done is showing this cycle has not yet dropped its
  // request, so it must not be granted again.
  assign ic_elig = ic_req & ~clr & ~ic_done_q;
  assign ls_elig = ls_req & ~ls_done_q;

  // Beat count for an LSB access; size 3 behaves as a word.
  always_comb begin
    ls_nbeat = 3'd4;
    case (ls_size)
      2'd0:    ls_nbeat = 3'd1;
      2'd1:    ls_nbeat = 3'd2;
      default: ls_nbeat = 3'd4;
    endcase
  end

  assign rd_lane = {rcv_q[1:0], 3'b000};
  assign wr_lane = {iss_q[1:0], 3'b000};

  // Next-state, beat sequencing and RAM port drive.
  always_comb begin
    state_d     = state_q;
    owner_ls_d  = owner_ls_q;
    last_ls_d   = last_ls_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    nbeat_d     = nbeat_q;
    iss_d       = iss_q;
    rcv_d       = rcv_q;
    rdata_d     = rdata_q;
    ic_done_d   = 1'b0;
    ic_data_d   = ic_data_q;
    ls_done_d   = 1'b0;
    ls_rdata_d  = ls_rdata_q;
    mem_a       = '0;
    mem_dout    = '0;
    mem_wr      = 1'b0;
    io_stall    = 1'b0;
    // A read address was issued last active cycle; its byte is on mem_din now.
    outstanding = (rcv_q != iss_q);

    case (state_q)
      S_IDLE: begin
        if (rdy) begin
          iss_d   = '0;
          rcv_d   = '0;
          rdata_d = '0;
          if (ic_elig && (!ls_elig || last_ls_q)) begin
            owner_ls_d = 1'b0;
            last_ls_d  = 1'b0;
            addr_d     = ic_addr;
            nbeat_d    = 3'd4;
            state_d    = S_READ;
          end else if (ls_elig) begin
            owner_ls_d = 1'b1;
            last_ls_d  = 1'b1;
            addr_d     = ls_addr;
            wdata_d    = ls_wdata;
            nbeat_d    = ls_nbeat;
            state_d    = ls_we ? S_WRITE : S_READ;
          end
        end
      end

      S_READ: begin
        if (rdy && clr && !owner_ls_q) begin
          state_d = S_IDLE;
        end else if (rdy) begin
          if (iss_q < nbeat_q) begin
            mem_a = addr_q + AW'(iss_q);
            iss_d = iss_q + 3'd1;
          end
          if (outstanding) begin
            rdata_d[rd_lane +: BW] = mem_din;
            rcv_d = rcv_q + 3'd1;
            if (rcv_q + 3'd1 == nbeat_q) begin
              state_d = S_IDLE;
              if (owner_ls_q) begin
                ls_done_d  = 1'b1;
                ls_rdata_d = rdata_d;
              end else begin
                ic_done_d = 1'b1;
                ic_data_d = rdata_d;
              end
            end
          end
        end else begin
          // Frozen: keep re-driving the address of the byte still owed so
          // mem_din carries it again on the first active cycle.
          mem_a = outstanding ? addr_q + AW'(rcv_q) : addr_q + AW'(iss_q);
        end
      end

      S_WRITE: begin
        mem_a    = addr_q + AW'(iss_q);
        mem_dout = wdata_q[wr_lane +: BW];
        io_stall = (mem_a >= IO_BASE) && io_buffer_full;
        if (rdy && !io_stall) begin
          mem_wr = 1'b1;
          iss_d  = iss_q + 3'd1;
          if (iss_q + 3'd1 == nbeat_q) begin
            state_d   = S_IDLE;
            ls_done_d = 1'b1;
          end
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      owner_ls_q <= 1'b0;
      last_ls_q  <= 1'b1;
      addr_q     <= '0;
      wdata_q    <= '0;
      nbeat_q    <= '0;
      iss_q      <= '0;
      rcv_q      <= '0;
      rdata_q    <= '0;
      ic_done_q  <= 1'b0;
      ic_data_q  <= '0;
      ls_done_q  <= 1'b0;
      ls_rdata_q <= '0;
    end else begin
      state_q    <= state_d;
      owner_ls_q <= owner_ls_d;
      last_ls_q  <= last_ls_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      nbeat_q    <= nbeat_d;
      iss_q      <= iss_d;
      rcv_q      <= rcv_d;
      rdata_q    <= rdata_d;
      ic_done_q  <= ic_done_d;
      ic_data_q  <= ic_data_d;
      ls_done_q  <= ls_done_d;
      ls_rdata_q <= ls_rdata_d;
    end
  end

endmodule
